// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC datapath: ALU op codes, sequencer states
// and default operand/register-file geometry.
package ecc_pkg;

  localparam int ECC_DATA_W     = 128;
  localparam int ECC_REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MULT = 2'b01,
    OP_SQR  = 2'b10,
    OP_ILL  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/ecc_regfile.sv
// Operand register file: per-entry synchronous write with ALU writeback taking
// priority over a host write to the same index, async clear, three async reads.
module ecc_regfile
  import ecc_pkg::*;
#(
  parameter int DATA_W     = ECC_DATA_W,
  parameter int REG_ADDR_W = ECC_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  host_wr_en,
  input  logic [REG_ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0]     host_wr_data,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0]     rd_a_data,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0]     rd_b_data,
  input  logic [REG_ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0]     host_rd_data
);

  localparam int DEPTH = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] rf_r [DEPTH];

  // Entry update: writeback beats a host write aimed at the same index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_en && (wb_addr == REG_ADDR_W'(i))) begin
          rf_r[i] <= wb_data;
        end else if (host_wr_en && (host_wr_addr == REG_ADDR_W'(i))) begin
          rf_r[i] <= host_wr_data;
        end
      end
    end
  end

  assign rd_a_data    = rf_r[rd_a_addr];
  assign rd_b_data    = rf_r[rd_b_addr];
  assign host_rd_data = rf_r[host_rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-command initiator for the GF(2^128) ALU: capture operands, pulse an
// enable, await done, write back, respond. Build macro SEQ_TIMEOUT_EN adds a WAIT abort.
module alu_op_sequencer
  import ecc_pkg::*;
#(
  parameter int DATA_W         = ECC_DATA_W,
  parameter int REG_ADDR_W     = ECC_REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_src_a,
  input  logic [REG_ADDR_W-1:0] cmd_src_b,
  input  logic [REG_ADDR_W-1:0] cmd_dst,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_data,
  input  logic                  host_wr_en,
  input  logic [REG_ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0]     host_wr_data,
  input  logic [REG_ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0]     host_rd_data,
  output logic [DATA_W-1:0]     alu_da,
  output logic [DATA_W-1:0]     alu_db,
  output logic                  alu_mult_enable,
  output logic                  alu_add_enable,
  output logic                  alu_sqr_enable,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_done
);

  seq_state_e            state_r, state_s;
  logic                  accept_s, wb_en_s, timeout_s;
  logic                  cmd_ready_r, err_r, rsp_valid_r, rsp_err_r;
  logic                  add_en_r, mult_en_r, sqr_en_r;
  logic [REG_ADDR_W-1:0] dst_r;
  logic [DATA_W-1:0]     result_r, rsp_data_r, alu_da_r, alu_db_r;
  logic [DATA_W-1:0]     rd_a_s, rd_b_s;

  ecc_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .wb_en        (wb_en_s),
    .wb_addr      (dst_r),
    .wb_data      (alu_result),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .rd_a_addr    (cmd_src_a),
    .rd_a_data    (rd_a_s),
    .rd_b_addr    (cmd_src_b),
    .rd_b_data    (rd_b_s),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_r;

  // WAIT-cycle counter, held at zero outside WAIT so it restarts on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign timeout_s = (state_r == ST_WAIT) && !alu_done &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the abort path the limit is irrelevant; this is constant false.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state decode; alu_done is only honoured in WAIT.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    wb_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s = 1'b1;
          if (cmd_op == OP_ILL) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) begin
          wb_en_s = 1'b1;
          state_s = ST_RESP;
        end else if (timeout_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, operand capture and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      add_en_r    <= 1'b0;
      mult_en_r   <= 1'b0;
      sqr_en_r    <= 1'b0;
      dst_r       <= {REG_ADDR_W{1'b0}};
      alu_da_r    <= {DATA_W{1'b0}};
      alu_db_r    <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
      result_r    <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      add_en_r    <= accept_s && (cmd_op == OP_ADD);
      mult_en_r   <= accept_s && (cmd_op == OP_MULT);
      sqr_en_r    <= accept_s && (cmd_op == OP_SQR);
      if (accept_s) begin
        dst_r    <= cmd_dst;
        alu_da_r <= rd_a_s;
        alu_db_r <= (cmd_op == OP_SQR) ? {DATA_W{1'b0}} : rd_b_s;
        err_r    <= (cmd_op == OP_ILL);
        result_r <= {DATA_W{1'b0}};
      end else if (wb_en_s) begin
        result_r <= alu_result;
      end else if (timeout_s) begin
        err_r    <= 1'b1;
      end
      rsp_valid_r <= (state_r == ST_RESP);
      rsp_err_r   <= (state_r == ST_RESP) && err_r;
      rsp_data_r  <= (state_r == ST_RESP) ? result_r : {DATA_W{1'b0}};
    end
  end

  assign cmd_ready       = cmd_ready_r;
  assign rsp_valid       = rsp_valid_r;
  assign rsp_err         = rsp_err_r;
  assign rsp_data        = rsp_data_r;
  assign alu_da          = alu_da_r;
  assign alu_db          = alu_db_r;
  assign alu_add_enable  = add_en_r;
  assign alu_mult_enable = mult_en_r;
  assign alu_sqr_enable  = sqr_en_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU of configurable
// latency; the timeout scenario is compiled in with SEQ_TIMEOUT_EN.
module tb_alu_op_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [2:0]   cmd_src_a = 3'd0, cmd_src_b = 3'd0, cmd_dst = 3'd0;
  logic         rsp_valid, rsp_err;
  logic [127:0] rsp_data;
  logic         host_wr_en = 1'b0;
  logic [2:0]   host_wr_addr = 3'd0, host_rd_addr = 3'd0;
  logic [127:0] host_wr_data = 128'd0, host_rd_data;
  logic [127:0] alu_da, alu_db, alu_result;
  logic         alu_mult_enable, alu_add_enable, alu_sqr_enable, alu_done;

  typedef struct {
    logic         err;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0, cyc = 0;
  int   n_add = 0, n_mult = 0, n_sqr = 0;
  int   alu_delay = 2;
  bit   alu_mute = 1'b0;
  bit   prev_valid = 1'b0;

  alu_op_sequencer #(.DATA_W(128), .REG_ADDR_W(3), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .alu_da(alu_da), .alu_db(alu_db), .alu_mult_enable(alu_mult_enable),
    .alu_add_enable(alu_add_enable), .alu_sqr_enable(alu_sqr_enable),
    .alu_result(alu_result), .alu_done(alu_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r = 128'd0;
    for (int i = 0; i < 128; i++) if (b[i]) r ^= (a << i);
    return r;
  endfunction

  // Behavioural ALU: done (with result) appears alu_delay cycles after the ISSUE cycle.
  initial begin
    logic [127:0] res;
    alu_done = 1'b0;
    alu_result = 128'd0;
    forever begin
      @(negedge clk);
      if (rst && !alu_mute && (alu_add_enable || alu_mult_enable || alu_sqr_enable)) begin
        if (alu_add_enable) res = alu_da ^ alu_db;
        else if (alu_mult_enable) res = clmul(alu_da, alu_db);
        else res = clmul(alu_da, alu_da);
        repeat (alu_delay) @(posedge clk);
        #1; alu_done = 1'b1; alu_result = res;
        @(posedge clk);
        #1; alu_done = 1'b0; alu_result = 128'd0;
      end
    end
  end

  // Enable pulse counting and one-hot check.
  always @(negedge clk) begin
    if (rst) begin
      n_add  += int'(alu_add_enable);
      n_mult += int'(alu_mult_enable);
      n_sqr  += int'(alu_sqr_enable);
      if (int'(alu_add_enable) + int'(alu_mult_enable) + int'(alu_sqr_enable) > 1)
        chk("en_onehot", {125'd0, alu_add_enable, alu_mult_enable, alu_sqr_enable}, 128'd1);
    end
  end

  // Response monitor: pop the scoreboard on every rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (prev_valid) begin
        chk("rsp_data_clear", rsp_data, 128'd0);
        chk("rsp_err_clear", {127'd0, rsp_err}, 128'd0);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {127'd0, rsp_valid}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", {127'd0, rsp_err}, {127'd0, e.err});
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
      prev_valid = rsp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic host_wr(input logic [2:0] a, input logic [127:0] d);
    @(negedge clk);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [127:0] exp);
    @(negedge clk);
    host_rd_addr = a;
    #1;
    chk(name, host_rd_data, exp);
  endtask

  // Offer a command; returns #1 into the cycle after acceptance.
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] d, input logic e_err, input logic [127:0] e_data,
                        input int lat, input bit expect_rsp);
    exp_t e;
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", {127'd0, cmd_ready}, 128'd1);
    end else if (expect_rsp) begin
      e.err = e_err; e.data = e_data; e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    logic ready_seen;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
    chk("rst_rsp", {125'd0, rsp_valid, rsp_err, alu_done}, 128'd0);
    chk("rst_ens", {125'd0, alu_add_enable, alu_mult_enable, alu_sqr_enable}, 128'd0);
    chk("rst_da", alu_da, 128'd0);
    chk("rst_rf0", host_rd_data, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // add: rf1=F0, rf2=0F, D=2, latency 5
    host_wr(3'd1, 128'hF0);
    host_wr(3'd2, 128'h0F);
    n_add = 0; n_mult = 0; n_sqr = 0;
    alu_delay = 2;
    do_cmd(2'b00, 3'd1, 3'd2, 3'd3, 1'b0, 128'hFF, 5, 1'b1);
    @(negedge clk);
    chk("add_issue_en", {127'd0, alu_add_enable}, 128'd1);
    chk("add_da", alu_da, 128'hF0);
    chk("add_db", alu_db, 128'h0F);
    wait_drain();
    chk("add_pulses", 128'({n_add, n_mult, n_sqr}), 128'({32'd1, 32'd0, 32'd0}));
    rd_chk("add_rf3", 3'd3, 128'hFF);

    // mult: 3*5 carryless = F, D=65, latency 68, cmd_ready low throughout
    host_wr(3'd1, 128'h3);
    host_wr(3'd2, 128'h5);
    n_add = 0; n_mult = 0; n_sqr = 0;
    alu_delay = 65;
    do_cmd(2'b01, 3'd1, 3'd2, 3'd4, 1'b0, 128'hF, 68, 1'b1);
    ready_seen = 1'b0;
    repeat (67) begin
      @(negedge clk);
      ready_seen |= cmd_ready;
    end
    chk("mult_ready_low", {127'd0, ready_seen}, 128'd0);
    wait_drain();
    chk("mult_pulses", 128'({n_add, n_mult, n_sqr}), 128'({32'd0, 32'd1, 32'd0}));
    rd_chk("mult_rf4", 3'd4, 128'hF);

    // illegal op: error response 2 cycles after accept, no ALU activity, rf untouched
    n_add = 0; n_mult = 0; n_sqr = 0;
    do_cmd(2'b11, 3'd1, 3'd2, 3'd3, 1'b1, 128'd0, 2, 1'b1);
    wait_drain();
    chk("ill_pulses", 128'(n_add + n_mult + n_sqr), 128'd0);
    rd_chk("ill_rf3", 3'd3, 128'hFF);

    // host write to a source during WAIT; host write to dst in the writeback cycle
    host_wr(3'd1, 128'hA0);
    host_wr(3'd2, 128'h05);
    alu_delay = 4;
    do_cmd(2'b00, 3'd1, 3'd2, 3'd6, 1'b0, 128'hA5, 7, 1'b1);
    @(posedge clk); #1;
    host_wr_en = 1'b1; host_wr_addr = 3'd1; host_wr_data = 128'h11;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    host_wr_en = 1'b1; host_wr_addr = 3'd6; host_wr_data = 128'h77;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    wait_drain();
    rd_chk("wb_wins_rf6", 3'd6, 128'hA5);
    rd_chk("host_rf1", 3'd1, 128'h11);

    // sqr of rf2 (0x05 -> 0x11); alu_db forced to zero despite src_b=rf1
    alu_delay = 1;
    do_cmd(2'b10, 3'd2, 3'd1, 3'd7, 1'b0, 128'h11, 4, 1'b1);
    @(negedge clk);
    chk("sqr_db_zero", alu_db, 128'd0);
    chk("sqr_da", alu_da, 128'h05);
    wait_drain();
    rd_chk("sqr_rf7", 3'd7, 128'h11);

    // reset during WAIT: command abandoned, everything cleared
    alu_delay = 20;
    do_cmd(2'b00, 3'd1, 3'd2, 3'd5, 1'b0, 128'd0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {127'd0, cmd_ready}, 128'd1);
    chk("mid_rst_rsp", {126'd0, rsp_valid, rsp_err}, 128'd0);
    chk("mid_rst_data", rsp_data, 128'd0);
    chk("mid_rst_da", alu_da, 128'd0);
    chk("mid_rst_db", alu_db, 128'd0);
    for (int i = 0; i < 8; i++) begin
      host_rd_addr = 3'(i);
      #1;
      chk("mid_rst_rf", host_rd_data, 128'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_ready", {127'd0, cmd_ready}, 128'd1);

`ifdef SEQ_TIMEOUT_EN
    // ALU never answers: error after 10 WAIT cycles, dst untouched, late done ignored
    host_wr(3'd3, 128'h12);
    alu_mute = 1'b1;
    do_cmd(2'b01, 3'd1, 3'd2, 3'd3, 1'b1, 128'd0, 13, 1'b1);
    wait_drain();
    @(posedge clk); #1;
    alu_done = 1'b1; alu_result = 128'h99;
    @(posedge clk); #1;
    alu_done = 1'b0; alu_result = 128'd0;
    repeat (5) @(negedge clk);
    rd_chk("to_rf3", 3'd3, 128'h12);
    chk("to_ready", {127'd0, cmd_ready}, 128'd1);
    alu_mute = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
